// File: rtl/conv_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_rd_pkg
// Brief  : Shared types, default widths and width helper for the readout path
// Rev    : 1.0  initial release
// ============================================================================
package conv_rd_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KICK  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(7 * 7);

endpackage
`default_nettype wire

// File: rtl/conv_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module : conv_rd_fifo
// Brief  : Small synchronous FIFO holding {last, data} words for the stream
// Rev    : 1.0  initial release
// ============================================================================
module conv_rd_fifo
    import conv_rd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEF_DATA_W + 1
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int c_ptr_w = cnt_w(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_wr;
    logic               w_rd;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_cnt_w'(DEPTH));
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only accepted when a pop frees the slot
    assign w_wr = push && (!full || pop);
    assign w_rd = pop && !empty;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_readout_seq.sv
`default_nettype none
// ============================================================================
// Module : conv_readout_seq
// Brief  : Launches conv_top, walks its output buffer and streams the words
// Rev    : 1.0  initial release
// ============================================================================
module conv_readout_seq
    import conv_rd_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROWS       = 7,
    parameter int COLS       = 7,
    parameter int ROW_PITCH  = 7,
    parameter int BASE_ADDR  = 0,
    parameter int START_WAIT = 40,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              conv_en,
    output logic              read,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int c_total  = ROWS * COLS;
    localparam int c_cnt_w  = cnt_w(c_total);
    localparam int c_wait_w = cnt_w(START_WAIT);
    localparam int c_fcnt_w = $clog2(FIFO_DEPTH + 1);

    state_t              r_state;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_cnt_w-1:0]  r_row;
    logic [c_cnt_w-1:0]  r_col;
    logic [c_cnt_w-1:0]  r_idx;
    logic                r_rd_last;
    logic [RD_LAT-1:0]   r_sr_vld;
    logic [RD_LAT-1:0]   r_sr_last;
    logic [c_fcnt_w-1:0] r_inflight;

    logic [c_fcnt_w-1:0] w_fifo_count;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [DATA_W:0]     w_fifo_rdata;
    logic                w_push;
    logic                w_pop;
    logic                w_credit;
    logic                w_issue_slot;
    logic                w_issue;
    logic                w_last_issue;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_drained;

    // Every issued read owns a FIFO slot until popped, so the FIFO cannot overflow
    assign w_credit     = !w_fifo_full &&
                          ((32'(r_inflight) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH));
    // The WAIT-exit cycle already issues word 0 so the first read lands on time
    assign w_issue_slot = (r_state == ST_READ) ||
                          ((r_state == ST_WAIT) && (r_wait_cnt == '0));
    assign w_issue      = w_issue_slot && w_credit;
    assign w_last_issue = (r_idx == c_cnt_w'(c_total - 1));
    assign w_addr       = ADDR_W'(BASE_ADDR) + ADDR_W'(r_row) * ADDR_W'(ROW_PITCH)
                          + ADDR_W'(r_col);

    assign w_push    = r_sr_vld[RD_LAT-1];
    assign out_valid = !w_fifo_empty;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = w_fifo_empty ? '0 : w_fifo_rdata[DATA_W-1:0];
    assign out_last  = !w_fifo_empty && w_fifo_rdata[DATA_W];

    // Finish in the same edge that pops the final word
    assign w_drained = (r_inflight == '0) && !w_push &&
                       ((w_fifo_count == '0) ||
                        ((w_fifo_count == c_fcnt_w'(1)) && w_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_rd_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            conv_en    <= 1'b0;
            read       <= 1'b0;
            addr       <= '0;
        end else begin
            conv_en   <= 1'b0;
            read      <= 1'b0;
            done      <= 1'b0;
            r_rd_last <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_KICK;
                        busy    <= 1'b1;
                        conv_en <= 1'b1;
                    end
                end
                ST_KICK: begin
                    r_wait_cnt <= c_wait_w'(START_WAIT - 1);
                    r_row      <= '0;
                    r_col      <= '0;
                    r_idx      <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_READ;
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_issue) begin
                read      <= 1'b1;
                addr      <= w_addr;
                r_rd_last <= w_last_issue;
                r_idx     <= r_idx + 1'b1;
                if (r_col == c_cnt_w'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_last_issue) begin
                    r_state <= ST_DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_vld   <= '0;
            r_sr_last  <= '0;
            r_inflight <= '0;
        end else begin
            r_sr_vld[0]  <= read;
            r_sr_last[0] <= r_rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_last[i] <= r_sr_last[i-1];
            end
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    conv_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata ({r_sr_last[RD_LAT-1], data_in}),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .count (w_fifo_count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_conv_readout_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_readout_seq
// Brief  : Self-checking bench for conv_readout_seq (vectors + scoreboard)
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_readout_seq;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int NW = 49;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic       rst;
        logic       start;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_p = 1'b0;
    logic out_ready = 1'b1;
    logic ready_p = 1'b1;

    logic          busy, done, conv_en, read, out_valid, out_last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] out_data;

    logic          busy_p, done_p, conv_en_p, read_p, out_valid_p, out_last_p;
    logic [AW-1:0] addr_p;
    logic [DW-1:0] data_in_p = '0;
    logic [DW-1:0] out_data_p;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int issued, popped, max_out, n_conv, n_done, n_done_p;
    int conv_cyc, first_rd_cyc, done_cyc;

    word_t         exp_w[$];
    logic [AW-1:0] exp_a[$];
    logic [AW-1:0] exp_ap[$];
    vec_t          vt[8];

    always #5 clk = ~clk;

    // conv_top result memory stand-in: one-cycle read, DATA_OUT = addr*3
    always @(posedge clk) if (read)   data_in   <= {10'd0, addr} * 16'd3;
    always @(posedge clk) if (read_p) data_in_p <= {10'd0, addr_p} * 16'd3;

    conv_readout_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .conv_en(conv_en), .read(read), .addr(addr), .data_in(data_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    conv_readout_seq #(.ROW_PITCH(8), .BASE_ADDR(14)) dut_p (
        .clk(clk), .rst(rst), .start(start_p), .busy(busy_p), .done(done_p),
        .conv_en(conv_en_p), .read(read_p), .addr(addr_p), .data_in(data_in_p),
        .out_data(out_data_p), .out_valid(out_valid_p), .out_ready(ready_p),
        .out_last(out_last_p)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    // Score the current cycle (inputs already set for the coming edge), then advance
    task automatic step();
        word_t         w;
        logic [AW-1:0] a;
        if (conv_en) begin n_conv++; conv_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (done_p) n_done_p++;
        if (read) begin
            issued++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (exp_a.size() == 0) chk("read_extra", 32'(read), 0);
            else begin a = exp_a.pop_front(); chk("rd_addr", 32'(addr), 32'(a)); end
        end
        if (read_p) begin
            if (exp_ap.size() == 0) chk("read_p_extra", 32'(read_p), 0);
            else begin a = exp_ap.pop_front(); chk("rd_addr_pitch", 32'(addr_p), 32'(a)); end
        end
        if (out_valid) begin
            if (exp_w.size() == 0) chk("valid_extra", 32'(out_valid), 0);
            else begin
                w = exp_w[0];
                chk("out_data", 32'(out_data), 32'(w.data));
                chk("out_last", 32'(out_last), 32'(w.last));
                if (out_ready) begin
                    void'(exp_w.pop_front());
                    popped++;
                end
            end
        end
        if (issued - popped > max_out) max_out = issued - popped;
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_stats();
        issued = 0; popped = 0; max_out = 0; n_conv = 0; n_done = 0; n_done_p = 0;
        conv_cyc = 0; first_rd_cyc = -1; done_cyc = 0;
    endtask

    task automatic push_job(input bit with_pitch);
        word_t w;
        for (int i = 0; i < NW; i++) begin
            exp_a.push_back(AW'(i));
            w.data = DW'(i * 3);
            w.last = (i == NW - 1);
            exp_w.push_back(w);
            if (with_pitch) exp_ap.push_back(AW'((14 + (i / 7) * 8 + (i % 7)) % 64));
        end
    endtask

    task automatic wait_words(input int n, input int lim);
        int k = 0;
        while (popped < n && k < lim) begin step(); k++; end
        if (popped < n) chk("timeout_words", 32'(popped), 32'(n));
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (n_done == 0 && k < lim) begin step(); k++; end
        if (n_done == 0) chk("timeout_done", 32'(n_done), 1);
    endtask

    initial begin
        // {rst, start} -> {busy, conv_en, read, done, out_valid}
        vt[0] = '{1'b1, 1'b0, 5'b00000};
        vt[1] = '{1'b0, 1'b0, 5'b00000};
        vt[2] = '{1'b0, 1'b1, 5'b11000};
        vt[3] = '{1'b0, 1'b0, 5'b10000};
        vt[4] = '{1'b0, 1'b1, 5'b10000};
        vt[5] = '{1'b0, 1'b0, 5'b10000};
        vt[6] = '{1'b1, 1'b0, 5'b00000};
        vt[7] = '{1'b0, 1'b0, 5'b00000};

        clear_stats();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rst = vt[i].rst;
            start = vt[i].start;
            step();
            chk($sformatf("vec%0d", i), 32'({busy, conv_en, read, done, out_valid}),
                32'(vt[i].exp));
        end
        start = 1'b0;

        // Nominal job on both instances
        clear_stats();
        push_job(1'b1);
        start = 1'b1; start_p = 1'b1;
        step();
        start = 1'b0; start_p = 1'b0;
        wait_done(300);
        repeat (3) step();
        chk("conv_en_count", 32'(n_conv), 1);
        chk("first_read_delay", 32'(first_rd_cyc - conv_cyc), 41);
        chk("job_len_in_range", 32'((done_cyc - conv_cyc >= 91) && (done_cyc - conv_cyc <= 93)), 1);
        chk("done_count", 32'(n_done), 1);
        chk("done_p_count", 32'(n_done_p), 1);
        chk("words_popped", 32'(popped), NW);
        chk("words_left", 32'(exp_w.size()), 0);
        chk("addrs_left", 32'(exp_a.size()), 0);
        chk("pitch_addrs_left", 32'(exp_ap.size()), 0);

        // Backpressure plus start pulses while busy
        clear_stats();
        push_job(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_words(2, 200);
        out_ready = 1'b0;
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        wait_done(300);
        repeat (3) step();
        chk("bp_max_outstanding", 32'(max_out), 4);
        chk("bp_conv_en_count", 32'(n_conv), 1);
        chk("bp_done_count", 32'(n_done), 1);
        chk("bp_words_popped", 32'(popped), NW);
        chk("bp_words_left", 32'(exp_w.size()), 0);

        // Asynchronous reset in the middle of READ
        clear_stats();
        push_job(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_words(10, 200);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            32'({busy, conv_en, read, done, out_valid, out_last, addr, out_data}), 0);
        exp_w.delete();
        exp_a.delete();
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_no_done", 32'(n_done), 0);
        chk("rst_fifo_empty", 32'(out_valid), 0);

        // Fresh job after the abort
        clear_stats();
        push_job(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(300);
        repeat (3) step();
        chk("post_rst_done_count", 32'(n_done), 1);
        chk("post_rst_words", 32'(popped), NW);
        chk("post_rst_words_left", 32'(exp_w.size()), 0);
        chk("post_rst_addrs_left", 32'(exp_a.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
